// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the pipelined arithmetic blocks.
//   MODE_ADD / MODE_SUB : encodings of the add/subtract select input
//   signed_ovf()        : two's-complement overflow from the MSB carries
package pipe_arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Signed overflow happens when the carry into the MSB differs from the carry out of it.
    function automatic logic signed_ovf(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational W-bit ripple segment used by one pipeline stage of pipe_addsub.
//   a_seg, b_seg : operand segments (b already inverted for subtraction)
//   ci           : carry into the segment LSB
//   s_seg        : segment sum
//   co           : carry out of the segment MSB
//   c_msb_in     : carry into the segment MSB (for overflow detection)
module addsub_seg #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_seg,
    input  logic [W-1:0] b_seg,
    input  logic         ci,
    output logic [W-1:0] s_seg,
    output logic         co,
    output logic         c_msb_in
);

    localparam int unsigned WE = W + 1;

    logic [W:0] total;

    // One extra bit captures the carry out of the segment.
    always_comb begin
        total = {1'b0, a_seg} + {1'b0, b_seg} + WE'(ci);
    end

    assign s_seg    = total[W-1:0];
    assign co       = total[W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered by XOR.
    assign c_msb_in = a_seg[W-1] ^ b_seg[W-1] ^ total[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor with valid/ready handshake.
// The operands are cut into STAGES segments of SEG bits; stage k resolves
// segment k and registers its carry for stage k+1. Operand segments not yet
// consumed ride along in skew registers, finished sum segments ride along in
// deskew registers, so all N result bits leave the last stage together.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sub                 : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   cout                : carry out of MSB (0 = borrow when subtracting)
//   ovf                 : signed overflow
// Latency is STAGES cycles; the whole pipeline freezes while the output is
// valid and not taken.
module pipe_addsub
    import pipe_arith_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned SEG = N / STAGES;

    if (N < 2 || N > 64 || STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_addsub: N must be 2..64 and a multiple of STAGES");
    end

    // Every register moves together; a held output freezes the whole pipe.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned KU = k;
        // Operand bits still unresolved on entry to this stage, and after it.
        localparam int unsigned IW = N - KU * SEG;
        localparam int unsigned UP = IW - SEG;

        logic [IW-1:0]          a_i;
        logic [IW-1:0]          b_i;
        logic                   ci;
        logic                   v_i;
        logic [SEG-1:0]         s_seg;
        logic                   co;
        logic [(k+1)*SEG-1:0]   s_d;
        logic [2*UP:0]          ab_d;

        // Stage output registers.
        // ab_q packs {b upper, a upper, carry}; on the last stage it is just the carry.
        logic                   v_q;
        logic [(k+1)*SEG-1:0]   s_q;
        logic [2*UP:0]          ab_q;

        if (k == 0) begin : g_head
            assign a_i = a;
            assign b_i = (sub == MODE_SUB) ? ~b : b;
            assign ci  = (sub == MODE_ADD) ? cin : 1'b1;
            assign v_i = in_valid;
            assign s_d = s_seg;
        end else begin : g_body
            assign a_i = g_stage[k-1].ab_q[IW:1];
            assign b_i = g_stage[k-1].ab_q[2*IW:IW+1];
            assign ci  = g_stage[k-1].ab_q[0];
            assign v_i = g_stage[k-1].v_q;
            assign s_d = {s_seg, g_stage[k-1].s_q};
        end

        if (k < STAGES - 1) begin : g_mid
            logic c_msb_unused;

            addsub_seg #(
                .W        (SEG)
            ) u_seg (
                .a_seg    (a_i[SEG-1:0]),
                .b_seg    (b_i[SEG-1:0]),
                .ci       (ci),
                .s_seg    (s_seg),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );

            assign ab_d = {b_i[IW-1:SEG], a_i[IW-1:SEG], co};
        end else begin : g_last
            logic c_msb;

            addsub_seg #(
                .W        (SEG)
            ) u_seg (
                .a_seg    (a_i),
                .b_seg    (b_i),
                .ci       (ci),
                .s_seg    (s_seg),
                .co       (co),
                .c_msb_in (c_msb)
            );

            assign ab_d = co;

            // Overflow flag registered alongside the final stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf <= 1'b0;
                end else if (advance) begin
                    ovf <= signed_ovf(c_msb, co);
                end
            end

            assign out_valid = v_q;
            assign sum       = s_q;
            assign cout      = ab_q[0];
        end

        // Stage register: valid bit, deskewed sum, skewed operands and carry.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q  <= 1'b0;
                s_q  <= '0;
                ab_q <= '0;
            end else if (advance) begin
                v_q  <= v_i;
                s_q  <= s_d;
                ab_q <= ab_d;
            end
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: three configurations (16/2, 8/1, 8/4)
// run side by side, each with its own driver, scoreboard queue and monitor.
module tb_pipe_addsub;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_chk = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned N = (g == 0) ? 16 : 8;
        localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int          G = g;

        logic         rst, in_valid, in_ready, cin, sub;
        logic         out_valid, out_ready, cout, ovf;
        logic [N-1:0] a, b, sum;
        logic [N+1:0] exp_q[$];     // {ovf, cout, sum}
        int unsigned  acc_q[$];     // edge number of acceptance
        bit           started = 0;
        bit           free_run = 0;

        pipe_addsub #(.N(N), .STAGES(S)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        // Reference: plain integer arithmetic on unsigned and signed views.
        function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                               input logic mcin, input logic msub);
            longint       ua, ub, sa, sb, r, lim, tot;
            logic [N-1:0] s;
            logic         c, o;
            ua  = longint'(ma);
            ub  = longint'(mb);
            lim = longint'(1) << (N - 1);
            sa  = ma[N-1] ? ua - 2 * lim : ua;
            sb  = mb[N-1] ? ub - 2 * lim : ub;
            if (msub) begin
                s = N'(ua - ub);
                c = (ua >= ub);
                r = sa - sb;
            end else begin
                tot = ua + ub + longint'(mcin);
                s = N'(tot);
                c = (tot >= 2 * lim);
                r = sa + sb + longint'(mcin);
            end
            o = (r >= lim) || (r < -lim);
            return {o, c, s};
        endfunction

        function automatic logic [N-1:0] rnd_op();
            case ($urandom_range(0, 5))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(N-1){1'b0}}};
                3:       return {1'b0, {(N-1){1'b1}}};
                default: return N'($urandom);
            endcase
        endfunction

        task automatic dir_vec(input int i, output logic [N-1:0] da, output logic [N-1:0] db,
                               output logic dc, output logic ds);
            dc = 1'b0;
            ds = 1'b0;
            case (i)
                0: begin da = N'((64'd1 << (N / 2)) - 64'd1); db = N'(1); end
                1: begin da = '1; db = N'(1); end
                2: begin da = {1'b0, {(N-1){1'b1}}}; db = N'(1); end
                3: begin da = N'(5); db = N'(7); dc = 1'b1; ds = 1'b1; end
                4: begin da = {1'b1, {(N-1){1'b0}}}; db = N'(1); ds = 1'b1; end
                5: begin da = N'(8'h15); db = N'(8'hBA); dc = 1'b1; end
                6: begin da = '0; db = '0; ds = 1'b1; end
                default: begin da = '1; db = '1; dc = 1'b1; end
            endcase
        endtask

        // One cycle of stimulus; records the expectation if the op is accepted at the next edge.
        task automatic step(input logic v, input logic [N-1:0] ia, input logic [N-1:0] ib,
                            input logic icin, input logic isub, input logic ordy, output bit acc);
            @(negedge clk);
            in_valid  = v;
            a         = ia;
            b         = ib;
            cin       = icin;
            sub       = isub;
            out_ready = ordy;
            #1;
            acc = v && in_ready;
            if (acc) begin
                exp_q.push_back(model(ia, ib, icin, isub));
                acc_q.push_back(cyc + 1);
            end
        endtask

        task automatic drain();
            bit ok;
            int t = 0;
            while (exp_q.size() != 0 && t < 60) begin
                step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ok);
                t++;
            end
            check($sformatf("cfg%0d drain leftover", G), longint'(exp_q.size()), 0);
        endtask

        initial begin : drv
            bit           ok;
            logic [N-1:0] da, db;
            logic         dc, ds;
            int           i, t;

            rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
            cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            #1;
            check($sformatf("cfg%0d reset out_valid", G), out_valid, 0);
            check($sformatf("cfg%0d reset sum", G), sum, 0);
            check($sformatf("cfg%0d reset cout", G), cout, 0);
            check($sformatf("cfg%0d reset ovf", G), ovf, 0);
            check($sformatf("cfg%0d reset in_ready", G), in_ready, 1);
            started = 1;

            // Directed corner cases, back to back with one bubble, latency checked.
            free_run = 1;
            for (int k = 0; k < 8; k++) begin
                dir_vec(k, da, db, dc, ds);
                step(1'b1, da, db, dc, ds, 1'b1, ok);
                if (k == 2) step(1'b0, '1, '1, 1'b1, 1'b0, 1'b1, ok);
            end
            drain();
            free_run = 0;

            // Eight ops with out_ready low for three cycles mid-stream.
            i = 0;
            t = 0;
            while (i < 8 && t < 60) begin
                step(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), !(t >= 3 && t <= 5), ok);
                if (ok) i++;
                t++;
            end
            check($sformatf("cfg%0d stream accepted", G), longint'(i), 8);
            drain();

            // Random traffic with bubbles and back-pressure.
            repeat (300) begin
                step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 9) < 7, ok);
            end
            drain();

            // Reset with operations in flight: nothing may emerge afterwards.
            step(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b1, ok);
            step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1, 1'b1, ok);
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            #1;
            check($sformatf("cfg%0d midrst out_valid", G), out_valid, 0);
            check($sformatf("cfg%0d midrst sum", G), sum, 0);
            check($sformatf("cfg%0d midrst cout", G), cout, 0);
            check($sformatf("cfg%0d midrst ovf", G), ovf, 0);
            exp_q.delete();
            acc_q.delete();
            rst = 1'b0;
            out_ready = 1'b1;
            repeat (S + 6) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ok);
            done_cnt++;
        end

        initial begin : mon
            logic [N-1:0] p_sum;
            logic         p_cout, p_ovf;
            bit           p_stall;
            logic [N+1:0] e;
            int unsigned  ea;
            p_stall = 0;
            p_sum = '0; p_cout = 1'b0; p_ovf = 1'b0;
            forever begin
                @(negedge clk);
                #2;
                if (!started || rst) begin
                    p_stall = 0;
                    continue;
                end
                check($sformatf("cfg%0d in_ready rule", G), in_ready, !out_valid || out_ready);
                if (p_stall) begin
                    check($sformatf("cfg%0d stall hold", G), {out_valid, sum, cout, ovf},
                          {1'b1, p_sum, p_cout, p_ovf});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL cfg%0d unexpected result: got sum 0x%0h, expected no output", G, sum);
                    end else begin
                        e  = exp_q.pop_front();
                        ea = acc_q.pop_front();
                        check($sformatf("cfg%0d sum", G), sum, e[N-1:0]);
                        check($sformatf("cfg%0d cout", G), cout, e[N]);
                        check($sformatf("cfg%0d ovf", G), ovf, e[N+1]);
                        if (free_run) check($sformatf("cfg%0d latency edge", G), cyc, ea + S - 1);
                    end
                end
                p_stall = out_valid && !out_ready;
                p_sum   = sum;
                p_cout  = cout;
                p_ovf   = ovf;
            end
        end
    end

    initial begin : master
        int t;
        t = 0;
        while (done_cnt < 3 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < 3) begin
            n_chk++;
            $display("FAIL timeout: drivers finished %0d, expected 3", done_cnt);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake. It is the sequential successor to the combinational full adder.
- The operand is split into STAGES equal segments. One segment is resolved per pipeline stage, with the carry registered between stages.
- Sits on datapath arithmetic paths where a wide single-cycle carry chain would miss timing.
- Accepts one operation per cycle and returns results in order after a fixed latency.

Parameters:
- N, 16, operand/result width in bits. Legal range 2..64.
- STAGES, 2, number of pipeline stages (segments). N % STAGES must equal 0. Elaboration error otherwise.
- SEG, N/STAGES, derived localparam: segment width. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation present on a/b/cin/sub
- in_ready  out  1  block can accept an operation this cycle
- a  in  N  operand A, unsigned/two's complement
- b  in  N  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  0: a+b+cin; 1: a-b (a+~b+1, cin ignored)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  N  result, modulo 2^N
- cout  out  1  carry out of MSB. In sub mode, cout=0 means borrow (a<b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). All stage valid bits clear. sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 in the first cycle after reset is released. Reset mid-operation discards every in-flight operation; no result for it ever appears.
- Pipeline advance: advance = !out_valid || out_ready. in_ready = advance.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Stall: when advance=0, every pipeline register, including skew/deskew registers and valid bits, holds. Outputs stay stable while out_valid=1 && out_ready=0.
- Latency: exactly STAGES cycles from accept to out_valid, with no stalls. Throughput is 1 op/cycle.
- Stage k (0..STAGES-1):
  - adds segment k of a and b' (b' = sub ? ~b : b) with the registered carry from stage k-1.
  - Stage 0 carry-in = sub ? 1 : cin.
- Skew/deskew:
  - Operand segments above k are delayed through skew registers until their stage.
  - Completed lower sum segments are delayed through deskew registers so all N bits emerge together.
- Output flags: the last stage produces cout and ovf from its MSB carries.
- Bubbles: a cycle with in_valid=0 (or no accept) injects an invalid slot. Invalid slots advance like valid ones. The data in an invalid slot is don't-care but must not reach out_valid=1.
- STAGES=1: the block degenerates to a registered N-bit adder with 1-cycle latency. Same handshake rules apply.
- Simultaneous accept and output handshake in the same cycle is legal. The pipeline shifts by one.

Decomposition:
- Shared package pipe_arith_pkg holds:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - a function for the signed-overflow rule, reused by later arithmetic blocks.
- One sub-module, addsub_seg: a combinational SEG-bit adder with inputs a_seg, b_seg, ci, and outputs s_seg, co, c_msb_in. It is instantiated STAGES times with a generate loop.
- All registers stay in pipe_addsub.

Test Plan:
- N=16, STAGES=2: a=0x00FF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0100, cout=0, ovf=0. This checks carry crossing the segment boundary.
- N=16: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- N=16, sub=1: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Stream of 8 back-to-back ops with out_ready held low for 3 cycles mid-stream:
  - in_ready=0 during the stall and outputs are stable.
  - All 8 results emerge in order, with none lost or duplicated.
- Reset asserted with 2 ops in flight -> out_valid=0 and sum=0 on the next edge. No stale result appears after reset is released.
- N=8, STAGES=1: a=0x15, b=0xBA, cin=1 -> 1 cycle later sum=0xD0, cout=0. N=8, STAGES=4 with the same stimulus gives an identical result after 4 cycles.
